// File: rtl/btn_pkg.sv
// Shared types and constants for the button debounce block.
// Channel FSM states and default/simulation debounce lengths.
package btn_pkg;

  typedef enum logic {
    S_STABLE  = 1'b0,
    S_PENDING = 1'b1
  } chan_state_e;

  localparam int DEFAULT_STABLE_CYCLES = 1000000;
  localparam int SIM_STABLE_CYCLES     = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM/counter, strobes.
// Ports: clk, rst, raw in; level, press, rel, press_next (comb) out.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic press_next
);

  localparam int CTR_WIDTH = $clog2(STABLE_CYCLES + 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = CTR_WIDTH'(STABLE_CYCLES);
  localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

  logic                 sync1;
  logic                 sync2;
  chan_state_e          state;
  chan_state_e          state_n;
  logic [CTR_WIDTH-1:0] ctr;
  logic [CTR_WIDTH-1:0] ctr_n;
  logic                 level_n;
  logic                 rel_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= S_STABLE;
      ctr   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_n;
      ctr   <= ctr_n;
      level <= level_n;
      press <= press_next;
      rel   <= rel_n;
    end
  end

  // Counter tracks how many consecutive edges sync2 has disagreed with
  // level; the flip edge is the one where it already equals the target.
  always_comb begin
    state_n    = state;
    ctr_n      = ctr;
    level_n    = level;
    press_next = 1'b0;
    rel_n      = 1'b0;
    unique case (state)
      S_STABLE: begin
        if (sync2 != level) begin
          state_n = S_PENDING;
          ctr_n   = CTR_ONE;
        end else begin
          ctr_n = '0;
        end
      end
      S_PENDING: begin
        if (sync2 == level) begin
          state_n = S_STABLE;
          ctr_n   = '0;
        end else if (ctr == CTR_MAX) begin
          state_n    = S_STABLE;
          ctr_n      = '0;
          level_n    = sync2;
          press_next = sync2;
          rel_n      = ~sync2;
        end else begin
          ctr_n = ctr + CTR_ONE;
        end
      end
      default: begin
        state_n = S_STABLE;
        ctr_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_debounce.sv
// Debounced button bank: NUM_BTN independent channels plus any-press flag.
// Ports: clk, rst, btn_raw in; btn_level, btn_press, btn_release, btn_any_press out.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NUM_BTN       = 7,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               btn_any_press
);

  logic [NUM_BTN-1:0] press_next;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_raw[i]),
      .level      (btn_level[i]),
      .press      (btn_press[i]),
      .rel        (btn_release[i]),
      .press_next (press_next[i])
    );
  end

  // Reduce the channels' next-cycle strobes so the flag lines up
  // with btn_press instead of trailing it by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_any_press <= 1'b0;
    end else begin
      btn_any_press <= |press_next;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce: directed scenarios plus random bouncing,
// scored against a run-length reference model through an expectation queue.
module tb_btn_debounce;
  import btn_pkg::*;

  localparam int NB = 7;
  localparam int SC = SIM_STABLE_CYCLES;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          btn_any_press;

  btn_debounce #(
    .NUM_BTN       (NB),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .btn_any_press (btn_any_press)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic          any;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;
  int   exp_presses = 0;
  int   obs_presses = 0;

  // Reference: raw is seen by the debounce logic two edges after it is
  // sampled; a level flips once the seen value has disagreed with it on
  // SC+1 consecutive edges.
  logic [NB-1:0] h1 = '0;
  logic [NB-1:0] h2 = '0;
  logic [NB-1:0] mlev = '0;
  int            run [NB];

  always @(posedge clk) begin : model
    exp_t          e;
    logic [NB-1:0] seen;
    e = '0;
    if (rst) begin
      h1   = '0;
      h2   = '0;
      mlev = '0;
      for (int i = 0; i < NB; i++) run[i] = 0;
    end else begin
      seen = h2;
      h2   = h1;
      h1   = btn_raw;
      for (int i = 0; i < NB; i++) begin
        if (seen[i] != mlev[i]) run[i] = run[i] + 1;
        else run[i] = 0;
        if (run[i] == SC + 1) begin
          run[i]     = 0;
          mlev[i]    = seen[i];
          e.press[i] = seen[i];
          e.rel[i]   = ~seen[i];
        end
      end
      e.level = mlev;
      e.any   = |e.press;
      exp_presses = exp_presses + $countones(e.press);
    end
    q.push_back(e);
    started = 1'b1;
  end

  task automatic chk(input string nm, input logic [NB-1:0] act,
                     input logic [NB-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (started) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL queue_underflow at %0t: got 0 expected 1 entries",
                 $time);
      end else begin
        e = q.pop_front();
        if (rst) e = '0;
        chk("level", btn_level, e.level);
        chk("press", btn_press, e.press);
        chk("release", btn_release, e.rel);
        chk("any_press", {{(NB-1){1'b0}}, btn_any_press},
            {{(NB-1){1'b0}}, e.any});
        chk("exclusive", btn_press & btn_release, '0);
        obs_presses = obs_presses + $countones(btn_press);
      end
    end
  end

  task automatic drive(input logic [NB-1:0] v, input int n);
    btn_raw = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    drive('0, 20);
    drive(7'h01, 12);
    drive(7'h01 | 7'h08, 1);
    drive(7'h01, 1);
    drive(7'h01 | 7'h08, 1);
    drive(7'h01, 1);
    drive(7'h09, 12);
    drive(7'h0D, 3);
    drive(7'h09, 12);
    drive(7'h7F, 12);
    drive(7'h00, 12);
    drive(7'h20, 4);
    do_reset(2);
    drive(7'h20, 14);
    drive(7'h00, 12);
    for (int c = 0; c < 150; c++) begin
      logic [NB-1:0] v;
      v = btn_raw;
      for (int i = 0; i < NB; i++)
        if ($urandom_range(7) == 0) v[i] = ~v[i];
      drive(v, $urandom_range(1, 7));
    end
    drive(7'h00, 12);
    n_checks++;
    if (obs_presses != exp_presses) begin
      n_fail++;
      $display("FAIL press_total: got %0d expected %0d",
               obs_presses, exp_presses);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
